// File: rtl/eth_pcs_rx_block_lock_pkg.sv
// Shared 10GBASE-R PCS receive definitions: sync-header encodings and block-lock states.
package eth_pcs_params;

  localparam int W_SH = 2;
  localparam logic [W_SH-1:0] SH_DATA = 2'b01;
  localparam logic [W_SH-1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {ST_HUNT, ST_SLIP, ST_LOCKED} block_lock_state_t;

  function automatic logic sh_is_valid(input logic [W_SH-1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_ber_mon.sv
// hi-BER monitor: counts invalid sync headers per BER window while block lock is held.
module eth_pcs_ber_mon #(
  parameter int BER_WINDOW = 19531,
  parameter int BER_THRESH = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clk_en,
  input  logic       i_sh_valid,
  input  logic       i_block_lock,
  output logic       o_hi_ber,
  output logic [4:0] o_ber_cnt
);

  localparam int W_WIN = $clog2(BER_WINDOW);
  localparam logic [W_WIN-1:0] WIN_LAST = W_WIN'(BER_WINDOW - 1);
  localparam logic [4:0] THRESH = 5'(BER_THRESH);

  logic [W_WIN-1:0] win_cnt_q, win_cnt_d;
  logic [4:0]       ber_cnt_q, ber_cnt_d;
  logic             hi_ber_q, hi_ber_d;
  logic [4:0]       ber_next;

  always_comb begin
    win_cnt_d = win_cnt_q;
    ber_cnt_d = ber_cnt_q;
    hi_ber_d  = hi_ber_q;
    ber_next  = ber_cnt_q;
    if (!i_sh_valid && (ber_cnt_q < THRESH)) ber_next = ber_cnt_q + 5'd1;

    // Monitor is held cleared whenever lock is absent or being lost this cycle.
    if (!i_block_lock) begin
      win_cnt_d = '0;
      ber_cnt_d = '0;
      hi_ber_d  = 1'b0;
    end else if (i_clk_en) begin
      if (win_cnt_q == WIN_LAST) begin
        win_cnt_d = '0;
        ber_cnt_d = '0;
        hi_ber_d  = (ber_next >= THRESH);
      end else begin
        win_cnt_d = win_cnt_q + W_WIN'(1);
        ber_cnt_d = ber_next;
        if (ber_next >= THRESH) hi_ber_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      win_cnt_q <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      ber_cnt_q <= ber_cnt_d;
      hi_ber_q  <= hi_ber_d;
    end
  end

  assign o_hi_ber  = hi_ber_q;
  assign o_ber_cnt = ber_cnt_q;

endmodule

// File: rtl/eth_pcs_rx_block_lock.sv
// 10GBASE-R receive block-lock FSM: drives gearbox bit-slip until 66b alignment holds.
//   state      | meaning
//   ST_HUNT    | testing candidate alignment, counting consecutive valid headers
//   ST_SLIP    | slip issued, ignoring headers while the gearbox realigns
//   ST_LOCKED  | aligned, counting invalid headers per test window
module eth_pcs_rx_block_lock
  import eth_pcs_params::*;
#(
  parameter int N_SH_WIN     = 64,
  parameter int N_INV_LOCKED = 16,
  parameter int SLIP_WAIT    = 2,
  parameter int BER_WINDOW   = 19531,
  parameter int BER_THRESH   = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clk_en,
  input  logic [W_SH-1:0] i_sync_hdr,
  output logic            o_slip,
  output logic            o_block_lock,
  output logic            o_hi_ber,
  output logic [4:0]      o_ber_cnt
);

  localparam int W_SHC  = $clog2(N_SH_WIN);
  localparam int W_INV  = $clog2(N_INV_LOCKED + 1);
  localparam int W_WAIT = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [W_SHC-1:0]  SH_LAST   = W_SHC'(N_SH_WIN - 1);
  localparam logic [W_INV-1:0]  INV_LIMIT = W_INV'(N_INV_LOCKED);
  localparam logic [W_WAIT-1:0] WAIT_LOAD = W_WAIT'(SLIP_WAIT - 1);

  block_lock_state_t state_q, state_d;
  logic [W_SHC-1:0]  sh_cnt_q, sh_cnt_d;
  logic [W_INV-1:0]  inv_cnt_q, inv_cnt_d;
  logic [W_WAIT-1:0] wait_cnt_q, wait_cnt_d;
  logic              slip_q, slip_d;
  logic              lock_q, lock_d;
  logic [W_INV-1:0]  inv_next;
  logic              sh_valid;

  assign sh_valid = sh_is_valid(i_sync_hdr);

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_d     = 1'b0;
    lock_d     = lock_q;
    inv_next   = sh_valid ? inv_cnt_q : inv_cnt_q + W_INV'(1);

    if (i_clk_en) begin
      case (state_q)
        ST_HUNT: begin
          if (!sh_valid) begin
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = WAIT_LOAD;
            state_d    = ST_SLIP;
          end else if (sh_cnt_q == SH_LAST) begin
            lock_d    = 1'b1;
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
            state_d   = ST_LOCKED;
          end else begin
            sh_cnt_d = sh_cnt_q + W_SHC'(1);
          end
        end
        ST_LOCKED: begin
          // Losing lock takes precedence over the window boundary on the same block.
          if (inv_next == INV_LIMIT) begin
            lock_d     = 1'b0;
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = WAIT_LOAD;
            state_d    = ST_SLIP;
          end else if (sh_cnt_q == SH_LAST) begin
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
          end else begin
            sh_cnt_d  = sh_cnt_q + W_SHC'(1);
            inv_cnt_d = inv_next;
          end
        end
        ST_SLIP: begin
          if (wait_cnt_q == '0) state_d = ST_HUNT;
          else wait_cnt_d = wait_cnt_q - W_WAIT'(1);
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_HUNT;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
    end
  end

  // BER window starts on the block after lock is gained and clears on the block that loses it.
  eth_pcs_ber_mon #(
    .BER_WINDOW (BER_WINDOW),
    .BER_THRESH (BER_THRESH)
  ) u_ber_mon (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clk_en     (i_clk_en),
    .i_sh_valid   (sh_valid),
    .i_block_lock (lock_q & lock_d),
    .o_hi_ber     (o_hi_ber),
    .o_ber_cnt    (o_ber_cnt)
  );

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_lock.sv
// Scoreboard bench for eth_pcs_rx_block_lock with a shortened BER window of 100 blocks.
module tb_eth_pcs_rx_block_lock;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] sh  = 2'b00;
  logic       o_slip, o_block_lock, o_hi_ber;
  logic [4:0] o_ber_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       slip;
    logic       lock;
    logic       hb;
    logic [4:0] bc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  eth_pcs_rx_block_lock #(.BER_WINDOW(100)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_clk_en     (en),
    .i_sync_hdr   (sh),
    .o_slip       (o_slip),
    .o_block_lock (o_block_lock),
    .o_hi_ber     (o_hi_ber),
    .o_ber_cnt    (o_ber_cnt)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // One clock of stimulus; the expected outputs after the following edge are queued.
  task automatic step(input logic r, input logic e, input logic [1:0] h,
                      input logic x_slip, input logic x_lock, input logic x_hb, input int x_bc);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    sh  = h;
    x.slip = x_slip;
    x.lock = x_lock;
    x.hb   = x_hb;
    x.bc   = 5'(x_bc);
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("slip", {7'd0, o_slip}, {7'd0, x.slip});
        chk("block_lock", {7'd0, o_block_lock}, {7'd0, x.lock});
        chk("hi_ber", {7'd0, o_hi_ber}, {7'd0, x.hb});
        chk("ber_cnt", {3'd0, o_ber_cnt}, {3'd0, x.bc});
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  n;
    logic bad;

    // Reset, then 64 valid headers acquire lock.
    step(1, 0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 1, 2'b01, 0, (i == 63), 0, 0);

    // Locked: 15 invalid in one window keeps lock.
    n = 0;
    for (int j = 0; j < 64; j++) begin
      bad = (j % 4 == 0) && (j < 60);
      if (bad) n++;
      step(0, 1, bad ? 2'b00 : 2'b10, 0, 1, 0, n);
    end
    // 16 invalid in the next window: BER saturates, then lock falls with a slip.
    for (int k = 0; k < 16; k++)
      step(0, 1, (k % 2 == 0) ? 2'b00 : 2'b11, (k == 15), (k != 15), (k != 15), (k == 15) ? 0 : 16);

    // Slip wait ignores two bad headers, hunt, slip on block 10, relock.
    step(0, 1, 2'b11, 0, 0, 0, 0);
    step(0, 1, 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, (i % 2 == 0) ? 2'b01 : 2'b10, 0, 0, 0, 0);
    step(0, 1, 2'b00, 1, 0, 0, 0);
    step(0, 1, 2'b11, 0, 0, 0, 0);
    step(0, 1, 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 1, 2'b01, 0, (i == 63), 0, 0);

    // Half-rate enable with junk on disabled cycles.
    step(1, 1, 2'b01, 0, 0, 0, 0);
    for (int c = 0; c < 128; c++)
      step(0, (c % 2 == 0), (c % 2 == 0) ? 2'b01 : 2'b00, 0, (c >= 126), 0, 0);

    // hi-BER: one error every 6th block, then an error-free window.
    n = 0;
    for (int b = 0; b < 200; b++) begin
      bad = (b < 100) && (b % 6 == 5);
      if (bad) n++;
      step(0, 1, bad ? 2'b00 : 2'b01, 0, 1, (b >= 95) && (b < 199), (b < 99) ? n : 0);
    end

    // Raise hi-BER again, then reset mid-operation and relock from scratch.
    n = 0;
    for (int b = 0; b < 96; b++) begin
      bad = (b % 6 == 5);
      if (bad) n++;
      step(0, 1, bad ? 2'b00 : 2'b01, 0, 1, (b == 95), n);
    end
    step(1, 1, 2'b01, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 1, 2'b10, 0, (i == 63), 0, 0);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries not checked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
